// File: rtl/loba_merge_pkg.sv
// Shared types and widths for the LOBA segmented-product merge block.
// Segment values are mantissa << (k - K_BIAS); k below K_BIAS means the segment is absent.
package loba_merge_pkg;

   localparam int SEG_W  = 4;
   localparam int K_W    = 4;
   localparam int P_W    = 32;
   localparam int K_BIAS = 3;
   localparam int PROD_W = 2 * SEG_W;
   localparam int SH_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      HH = 2'd0,
      HL = 2'd1,
      LH = 2'd2,
      LL = 2'd3
   } term_t;

   typedef struct packed {
      logic [SEG_W-1:0] xh;
      logic [K_W-1:0]   kh;
      logic [SEG_W-1:0] xl;
      logic [K_W-1:0]   kl;
      logic [SEG_W-1:0] yh;
      logic [K_W-1:0]   jh;
      logic [SEG_W-1:0] yl;
      logic [K_W-1:0]   jl;
   } seg_t;

endpackage

// File: rtl/loba_merge_if.sv
// Operand/result handshake bundle for loba_merge.
// The master side offers operand pairs and consumes results; the slave is the merge block.
interface loba_merge_if;
   import loba_merge_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [SEG_W-1:0] Xh;
   logic [K_W-1:0]   kh;
   logic [SEG_W-1:0] Xl;
   logic [K_W-1:0]   kl;
   logic [SEG_W-1:0] Yh;
   logic [K_W-1:0]   jh;
   logic [SEG_W-1:0] Yl;
   logic [K_W-1:0]   jl;
   logic             out_valid;
   logic             out_ready;
   logic [P_W-1:0]   P;

   modport master (
      output in_valid, Xh, kh, Xl, kl, Yh, jh, Yl, jl, out_ready,
      input  in_ready, out_valid, P
   );

   modport slave (
      input  in_valid, Xh, kh, Xl, kl, Yh, jh, Yl, jl, out_ready,
      output in_ready, out_valid, P
   );

endinterface

// File: rtl/loba_merge_term.sv
// One shifted partial product a*b << (ka+kb-2*K_BIAS); zero when either segment is absent.
module loba_term
   import loba_merge_pkg::*;
(
   input  logic [SEG_W-1:0] a,
   input  logic [K_W-1:0]   ka,
   input  logic [SEG_W-1:0] b,
   input  logic [K_W-1:0]   kb,
   output logic [P_W-1:0]   term
);

   logic [PROD_W-1:0] prod;
   logic [SH_W-1:0]   ksum;
   logic [SH_W-1:0]   shift;
   logic              present;

   assign prod    = {{SEG_W{1'b0}}, a} * {{SEG_W{1'b0}}, b};
   assign ksum    = {1'b0, ka} + {1'b0, kb};
   assign present = (ka >= K_W'(K_BIAS)) && (kb >= K_W'(K_BIAS));
   // Only evaluated when both k >= K_BIAS, so the subtraction never wraps.
   assign shift   = ksum - SH_W'(2 * K_BIAS);
   assign term    = present ? (P_W'(prod) << shift) : '0;

endmodule

// File: rtl/loba_merge.sv
// Sequential merge of four segment products into one 32-bit approximate product,
// one term per cycle through a single shared term unit.
module loba_merge
   import loba_merge_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   loba_merge_if.slave  bus
);

   state_t          state;
   state_t          state_next;
   term_t           idx;
   seg_t            seg;
   logic [P_W-1:0]  acc;
   logic [P_W-1:0]  term;
   logic [SEG_W-1:0] a;
   logic [K_W-1:0]   ka;
   logic [SEG_W-1:0] b;
   logic [K_W-1:0]   kb;
   logic            accept;

   assign accept = (state == IDLE) && bus.in_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = ACC;
         ACC:     if (idx == LL)    state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
   end

   // HH, HL, LH, LL order: idx[1] picks the X segment, idx[0] the Y segment.
   always_comb begin
      a  = idx[1] ? seg.xl : seg.xh;
      ka = idx[1] ? seg.kl : seg.kh;
      b  = idx[0] ? seg.yl : seg.yh;
      kb = idx[0] ? seg.jl : seg.jh;
   end

   loba_term u_term (
      .a    (a),
      .ka   (ka),
      .b    (b),
      .kb   (kb),
      .term (term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         idx <= HH;
         seg <= '0;
      end else if (accept) begin
         acc <= '0;
         idx <= HH;
         seg <= '{xh: bus.Xh, kh: bus.kh, xl: bus.Xl, kl: bus.kl,
                  yh: bus.Yh, jh: bus.jh, yl: bus.Yl, jl: bus.jl};
      end else if (state == ACC) begin
         acc <= acc + term;
         idx <= term_t'(idx + 2'd1);
      end
   end

   assign bus.P = acc;

endmodule

// File: tb/tb_loba_merge.sv
// Directed bench for loba_merge: hand-computed products, fixed latency, hold, reset abort, throughput.
module tb_loba_merge;
   import loba_merge_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   loba_merge_if bus ();

   loba_merge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic driveSegs(input logic [3:0] xh, kh, xl, kl, yh, jh, yl, jl);
      bus.Xh = xh; bus.kh = kh; bus.Xl = xl; bus.kl = kl;
      bus.Yh = yh; bus.jh = jh; bus.Yl = yl; bus.jl = jl;
   endtask

   task automatic scrambleSegs();
      driveSegs(4'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()),
                4'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()));
   endtask

   // Offers one pair, scrambles the inputs during ACC, and stops with the block in DONE.
   task automatic applyStimulus(input string tag, input logic [3:0] xh, kh, xl, kl, yh, jh, yl, jl,
                                input logic [31:0] expP, input bit readyEarly);
      int  lat;
      bit  seen;
      @(negedge clk);
      driveSegs(xh, kh, xl, kl, yh, jh, yl, jl);
      bus.in_valid  = 1'b1;
      bus.out_ready = readyEarly;
      for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
      checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      scrambleSegs();
      checkOutput({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 10 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
      checkOutput({tag, "_P"}, bus.P, expP);
   endtask

   task automatic releaseResult(input string tag, input logic [31:0] expP);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, "_P_held"}, bus.P, expP);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc0;
      int acc1;
      int nacc;
      int vcount;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      driveSegs(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset_P", bus.P, 32'd0);
      checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("x16y16", 4'h8, 4'd4, 4'h0, 4'd0, 4'h8, 4'd4, 4'h0, 4'd0, 32'h0000_0100, 1'b0);
      releaseResult("x16y16", 32'h0000_0100);

      applyStimulus("xff", 4'hF, 4'd7, 4'hF, 4'd3, 4'hF, 4'd7, 4'hF, 4'd3, 32'h0000_FE01, 1'b0);
      releaseResult("xff", 32'h0000_FE01);

      applyStimulus("xffff", 4'hF, 4'd15, 4'hF, 4'd11, 4'hF, 4'd15, 4'hF, 4'd11, 32'hFE01_0000, 1'b1);
      releaseResult("xffff", 32'hFE01_0000);

      // Low X mantissa is nonzero but its position is 0, so it must not contribute.
      applyStimulus("x3y5", 4'h3, 4'd3, 4'hF, 4'd0, 4'h5, 4'd3, 4'h0, 4'd0, 32'h0000_000F, 1'b0);
      releaseResult("x3y5", 32'h0000_000F);

      applyStimulus("below_bias", 4'hF, 4'd2, 4'h0, 4'd0, 4'hF, 4'd5, 4'h0, 4'd0, 32'h0000_0000, 1'b1);
      releaseResult("below_bias", 32'h0000_0000);

      // 30<<3 + 18<<1 = 240 + 36
      applyStimulus("mixed", 4'h5, 4'd5, 4'h3, 4'd3, 4'h6, 4'd4, 4'h0, 4'd0, 32'h0000_0114, 1'b0);
      releaseResult("mixed", 32'h0000_0114);

      applyStimulus("hold", 4'hF, 4'd7, 4'hF, 4'd3, 4'hF, 4'd7, 4'hF, 4'd3, 32'h0000_FE01, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = ~bus.in_valid;
         scrambleSegs();
         @(posedge clk);
         #1;
         checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("hold_P", bus.P, 32'h0000_FE01);
         checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      releaseResult("hold", 32'h0000_FE01);

      // Abort during the second ACC cycle; HH is already in the accumulator.
      @(negedge clk);
      driveSegs(4'hF, 4'd15, 4'hF, 4'd11, 4'hF, 4'd15, 4'hF, 4'd11);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort_hh_first", bus.P, 32'hE100_0000);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_P", bus.P, 32'd0);
      checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort_ready", 32'(bus.in_ready), 32'd1);
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) vcount++;
      end
      checkOutput("abort_no_valid", 32'(vcount), 32'd0);
      applyStimulus("after_abort", 4'h8, 4'd4, 4'h0, 4'd0, 4'h8, 4'd4, 4'h0, 4'd0, 32'h0000_0100, 1'b0);
      releaseResult("after_abort", 32'h0000_0100);

      // Back-to-back with both handshakes held high: one acceptance every 6 cycles.
      @(negedge clk);
      driveSegs(4'h8, 4'd4, 4'h0, 4'd0, 4'h8, 4'd4, 4'h0, 4'd0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      acc0 = -1;
      acc1 = -1;
      nacc = 0;
      for (int c = 0; c < 20 && nacc < 2; c++) begin
         if (bus.in_ready) begin
            if (nacc == 0) acc0 = c;
            else           acc1 = c;
            nacc++;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      checkOutput("throughput_count", 32'(nacc), 32'd2);
      checkOutput("throughput_period", 32'(acc1 - acc0), 32'd6);
      for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
      bus.out_ready = 1'b0;
      checkOutput("throughput_P", bus.P, 32'h0000_0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/loba_merge.md
LOBA_MERGE -- requirements
Module: LOBA_MERGE

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these input-side ports: in_valid  in  1  operand pair offered; in_ready  out  1  block can accept an operand pair.
REQ-003 The block SHALL have these X-segment inputs: Xh  in  4  high mantissa of X; kh  in  4  high leading-one position of X; Xl  in  4  low mantissa of X; kl  in  4  low leading-one position of X, where 0 means absent.
REQ-004 The block SHALL have these Y-segment inputs: Yh  in  4  high mantissa of Y; jh  in  4  high leading-one position of Y; Yl  in  4  low mantissa of Y; jl  in  4  low leading-one position of Y, where 0 means absent.
REQ-005 The block SHALL have these output-side ports: out_valid  out  1  result available; out_ready  in  1  consumer takes the result; P  out  32  merged approximate product.

Function
REQ-006 Each segment SHALL denote the value mantissa << (k-3), with K_BIAS = 3.
REQ-007 The block SHALL compute P = sum over the four terms HH, HL, LH, LL of Xa*Yb << (ka+kb-6).
REQ-008 Any term with ka < 3 or kb < 3 SHALL contribute zero.
REQ-009 Each product SHALL be 8 bits unsigned, the shift SHALL be 5 bits in the range 0..24, and accumulation SHALL be 32 bits; no overflow is possible for valid segments.
REQ-010 The state machine SHALL have three states: IDLE, ACC and DONE.
REQ-011 IDLE: in_ready=1, out_valid=0; in_valid&&in_ready SHALL latch all eight segment inputs, clear P to 0, set term index to 0, and go to ACC.
REQ-012 ACC: in_ready=0; one term SHALL be added per cycle in the fixed order HH, HL, LH, LL; after the LL add the state SHALL go to DONE.
REQ-013 Latency SHALL be fixed: out_valid rises exactly 4 clock edges after the accepting edge, including for zero terms (no skipping).
REQ-014 DONE: out_valid=1 and P is stable; out_ready=1 SHALL return the state to IDLE on that edge.
REQ-015 in_ready SHALL first rise the following cycle (no same-cycle bypass).
REQ-016 P SHALL hold its value after DONE until the next acceptance clears it.
REQ-017 in_valid and segment inputs SHALL be ignored outside IDLE; input changes during ACC SHALL not affect P.
REQ-018 out_ready SHALL be ignored outside DONE.
REQ-019 Back-to-back throughput SHALL be one result per 6 cycles minimum when out_ready is held at 1.

Reset
REQ-020 rst=1 SHALL force IDLE, P=0, out_valid=0, in_ready=1 and term index=0, and clear the latched segments, taking effect at the next rising clk edge.
REQ-021 Reset asserted mid-ACC or in DONE SHALL abort the operation with no out_valid pulse; the first acceptance is possible on the edge after rst deasserts.

Structure
REQ-022 A shared package SHALL hold the state encoding (IDLE, ACC, DONE), the term-index encoding (HH=0, HL=1, LH=2, LL=3), K_BIAS=3, and the widths SEG_W=4, K_W=4 and P_W=32.
REQ-023 A single combinational sub-module LOBA_TERM SHALL take (a, ka, b, kb) and return the 32-bit shifted product, applying the k<3 zero rule.
REQ-024 LOBA_MERGE SHALL instantiate exactly one LOBA_TERM, with operands muxed by the term index.

Verification
REQ-025 X=16, Y=16: Xh=Yh=8, kh=jh=4, kl=jl=0 -> P=0x00000100, out_valid 4 edges after acceptance.
REQ-026 X=Y=0x00FF: Xh=Xl=Yh=Yl=0xF, kh=jh=7, kl=jl=3 -> P=0x0000FE01.
REQ-027 X=Y=0xFFFF: Xh=Xl=Yh=Yl=0xF, kh=jh=15, kl=jl=11 -> P=0xFE010000 (maximum; no overflow).
REQ-028 X=3, Y=5: Xh=3, kh=3, Yh=5, jh=3, low segments absent -> P=0x0000000F.
REQ-029 Hold out_ready=0 for 10 cycles in DONE -> out_valid and P stable throughout, in_ready=0; toggling in_valid and segment inputs -> no change to P.
REQ-030 Assert rst for 1 cycle during the 2nd ACC cycle -> P=0, out_valid never asserts, in_ready=1 the cycle after; a new operand pair then completes with the correct P.
